// File: rtl/alu_pkg.sv
// Shared definitions for the 16-bit sequencer that drives the external 8-bit ALU slice:
// ALU opcodes and mode, the 16-bit command set, and the sequencer state type.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_INC  = 4'b0010;
    localparam logic [3:0] OP_DEC  = 4'b0011;
    localparam logic [3:0] OP_ADC  = 4'b0100;
    localparam logic [3:0] OP_SBB  = 4'b0101;
    localparam logic [3:0] OP_PASS = 4'b0110;
    localparam logic [3:0] OP_OR   = 4'b0111;
    localparam logic [3:0] OP_AND  = 4'b1000;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_XOR  = 4'b1010;
    localparam logic [3:0] OP_SHL  = 4'b1011;
    localparam logic [3:0] OP_SHR  = 4'b1100;
    localparam logic [3:0] OP_ASR  = 4'b1101;
    localparam logic [3:0] OP_ROL  = 4'b1110;
    localparam logic [3:0] OP_ROR  = 4'b1111;

    localparam logic MODE_ARITH = 1'b0;
    localparam logic MODE_LOGIC = 1'b1;

    typedef enum logic [3:0] {
        CMD_ADD = 4'd0,
        CMD_SUB = 4'd1,
        CMD_CMP = 4'd2,
        CMD_INC = 4'd3,
        CMD_AND = 4'd4,
        CMD_OR  = 4'd5,
        CMD_XOR = 4'd6,
        CMD_NOT = 4'd7,
        CMD_SHL = 4'd8,
        CMD_SHR = 4'd9
    } cmd_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LO,
        ST_HI,
        ST_FIX,
        ST_DONE
    } state_e;

    function automatic logic cmd_legal(input logic [3:0] op);
        return op <= 4'(CMD_SHR);
    endfunction

    function automatic logic alu_mode_of(input logic [3:0] opcode);
        logic m;
        m = MODE_ARITH;
        case (opcode)
            OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_ADC, OP_SBB, OP_PASS: m = MODE_ARITH;
            OP_OR, OP_AND, OP_NOT, OP_XOR, OP_SHL, OP_SHR, OP_ASR, OP_ROL, OP_ROR: m = MODE_LOGIC;
        endcase
        return m;
    endfunction

    // The high pass of ADD/INC chains the low carry through ADC; SUB/CMP never use SBB
    // because the slice ignores cin there, so the borrow is repaired by a separate DEC pass.
    function automatic logic [3:0] pass_opcode(input cmd_op_e op, input logic hi_pass);
        logic [3:0] opcode;
        opcode = OP_PASS;
        case (op)
            CMD_ADD:          opcode = hi_pass ? OP_ADC : OP_ADD;
            CMD_SUB, CMD_CMP: opcode = OP_SUB;
            CMD_INC:          opcode = hi_pass ? OP_ADC : OP_INC;
            CMD_AND:          opcode = OP_AND;
            CMD_OR:           opcode = OP_OR;
            CMD_XOR:          opcode = OP_XOR;
            CMD_NOT:          opcode = OP_NOT;
            CMD_SHL:          opcode = OP_SHL;
            CMD_SHR:          opcode = OP_SHR;
            default:          opcode = OP_PASS;
        endcase
        return opcode;
    endfunction

endpackage

// File: rtl/alu16_flag_merge.sv
// Combines the per-pass results of a 16-bit command into the final V/Z/N/C flags.
module alu16_flag_merge
    import alu_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  cmd_op_e           op,
    input  logic              a15,
    input  logic              b15,
    input  logic              a0,
    input  logic [DATA_W-1:0] res,
    input  logic              hi_c,
    output logic              v,
    output logic              z,
    output logic              n,
    output logic              c
);

    logic r15;

    assign r15 = res[DATA_W-1];

    // hi_c is the high-pass carry for ADD/INC and the accumulated borrow for SUB/CMP.
    always_comb begin
        z = (res == '0);
        n = r15;
        v = 1'b0;
        c = 1'b0;
        case (op)
            CMD_ADD: begin
                c = hi_c;
                v = ~(a15 ^ b15) & (a15 ^ r15);
            end
            CMD_INC: begin
                c = hi_c;
                v = ~a15 & r15;
            end
            CMD_SUB: begin
                c = hi_c;
                v = (a15 ^ b15) & (a15 ^ r15);
            end
            CMD_CMP: begin
                c = ~hi_c;
                v = (a15 ^ b15) & (a15 ^ r15);
            end
            CMD_SHL: c = a15;
            CMD_SHR: c = a0;
            default: ;
        endcase
    end

endmodule

// File: rtl/alu16_seq.sv
// Sequences 16-bit commands through the external 8-bit ALU in low/high/fix passes.
// Optional macro ALU16_SEQ_STICKY_V_EN adds a sticky overflow flag (sticky_v/sticky_clr).
module alu16_seq
    import alu_pkg::*;
#(
    parameter int ALU_W  = 8,
    parameter int DATA_W = 2 * ALU_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_f,
    output logic              rsp_v,
    output logic              rsp_z,
    output logic              rsp_n,
    output logic              rsp_c,
    output logic              rsp_err,
    output logic [ALU_W-1:0]  alu_a,
    output logic [ALU_W-1:0]  alu_b,
    output logic              alu_cin,
    output logic [3:0]        alu_op,
    output logic              alu_mode,
    input  logic [ALU_W-1:0]  alu_f,
    input  logic              alu_v,
    input  logic              alu_z,
    input  logic              alu_n,
    input  logic              alu_c
`ifdef ALU16_SEQ_STICKY_V_EN
    ,
    output logic              sticky_v,
    input  logic              sticky_clr
`endif
);

    state_e            state_q, state_d;
    cmd_op_e           op_q, op_d;
    logic [ALU_W-1:0]  a_hi_q, a_hi_d;
    logic [ALU_W-1:0]  b_hi_q, b_hi_d;
    logic              a7_q, a7_d;
    logic              a0_q, a0_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              lo_c_q, lo_c_d;
    logic              hi_c_q, hi_c_d;

    logic [ALU_W-1:0]  alu_a_q, alu_a_d;
    logic [ALU_W-1:0]  alu_b_q, alu_b_d;
    logic              alu_cin_q, alu_cin_d;
    logic [3:0]        alu_op_q, alu_op_d;
    logic              alu_mode_q, alu_mode_d;

    logic [DATA_W-1:0] rsp_f_q, rsp_f_d;
    logic              rsp_v_q, rsp_v_d;
    logic              rsp_z_q, rsp_z_d;
    logic              rsp_n_q, rsp_n_d;
    logic              rsp_c_q, rsp_c_d;
    logic              rsp_err_q, rsp_err_d;

    logic              finish;
    logic              load_err;
    logic              is_sub;
    logic              m_v, m_z, m_n, m_c;
    logic              unused_alu_flags;

    assign unused_alu_flags = alu_v ^ alu_z ^ alu_n;

    assign cmd_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_DONE);
    assign is_sub    = (op_q == CMD_SUB) || (op_q == CMD_CMP);

    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_cin  = alu_cin_q;
    assign alu_op   = alu_op_q;
    assign alu_mode = alu_mode_q;

    assign rsp_f   = rsp_f_q;
    assign rsp_v   = rsp_v_q;
    assign rsp_z   = rsp_z_q;
    assign rsp_n   = rsp_n_q;
    assign rsp_c   = rsp_c_q;
    assign rsp_err = rsp_err_q;

    // Sequencer: each state captures the slice result of the pass issued on the previous edge
    // and registers the ALU inputs for the next pass.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_hi_d     = a_hi_q;
        b_hi_d     = b_hi_q;
        a7_d       = a7_q;
        a0_d       = a0_q;
        res_d      = res_q;
        lo_c_d     = lo_c_q;
        hi_c_d     = hi_c_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_cin_d  = alu_cin_q;
        alu_op_d   = alu_op_q;
        alu_mode_d = alu_mode_q;
        finish     = 1'b0;
        load_err   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_legal(cmd_op)) begin
                        op_d       = cmd_op_e'(cmd_op);
                        a_hi_d     = cmd_a[DATA_W-1:ALU_W];
                        b_hi_d     = cmd_b[DATA_W-1:ALU_W];
                        a7_d       = cmd_a[ALU_W-1];
                        a0_d       = cmd_a[0];
                        res_d      = '0;
                        lo_c_d     = 1'b0;
                        hi_c_d     = 1'b0;
                        alu_a_d    = cmd_a[ALU_W-1:0];
                        alu_b_d    = cmd_b[ALU_W-1:0];
                        alu_cin_d  = 1'b0;
                        alu_op_d   = pass_opcode(cmd_op_e'(cmd_op), 1'b0);
                        alu_mode_d = alu_mode_of(alu_op_d);
                        state_d    = ST_LO;
                    end else begin
                        load_err = 1'b1;
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_LO: begin
                res_d[ALU_W-1:0] = alu_f;
                lo_c_d           = alu_c;
                alu_a_d          = a_hi_q;
                alu_b_d          = b_hi_q;
                alu_cin_d        = 1'b0;
                alu_op_d         = pass_opcode(op_q, 1'b1);
                alu_mode_d       = alu_mode_of(alu_op_d);
                if (op_q == CMD_ADD) begin
                    alu_cin_d = alu_c;
                end
                if (op_q == CMD_INC) begin
                    alu_b_d   = '0;
                    alu_cin_d = alu_c;
                end
                state_d = ST_HI;
            end
            ST_HI: begin
                res_d[DATA_W-1:ALU_W] = alu_f;
                hi_c_d                = alu_c;
                if (op_q == CMD_SHL) begin
                    res_d[ALU_W] = alu_f[0] | a7_q;
                end
                if (op_q == CMD_SHR) begin
                    res_d[ALU_W-1] = res_q[ALU_W-1] | a_hi_q[0];
                end
                if (is_sub && lo_c_q) begin
                    alu_a_d    = alu_f;
                    alu_b_d    = '0;
                    alu_cin_d  = 1'b0;
                    alu_op_d   = OP_DEC;
                    alu_mode_d = MODE_ARITH;
                    state_d    = ST_FIX;
                end else begin
                    finish  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_FIX: begin
                res_d[DATA_W-1:ALU_W] = alu_f;
                hi_c_d                = hi_c_q | alu_c;
                finish                = 1'b1;
                state_d               = ST_DONE;
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    alu16_flag_merge #(
        .DATA_W (DATA_W)
    ) u_flag_merge (
        .op   (op_q),
        .a15  (a_hi_q[ALU_W-1]),
        .b15  (b_hi_q[ALU_W-1]),
        .a0   (a0_q),
        .res  (res_d),
        .hi_c (hi_c_d),
        .v    (m_v),
        .z    (m_z),
        .n    (m_n),
        .c    (m_c)
    );

    // Response registers are loaded from the next-state result so they are valid on entry to DONE.
    always_comb begin
        rsp_f_d   = rsp_f_q;
        rsp_v_d   = rsp_v_q;
        rsp_z_d   = rsp_z_q;
        rsp_n_d   = rsp_n_q;
        rsp_c_d   = rsp_c_q;
        rsp_err_d = rsp_err_q;
        if (finish) begin
            rsp_f_d   = (op_q == CMD_CMP) ? '0 : res_d;
            rsp_v_d   = m_v;
            rsp_z_d   = m_z;
            rsp_n_d   = m_n;
            rsp_c_d   = m_c;
            rsp_err_d = 1'b0;
        end else if (load_err) begin
            rsp_f_d   = '0;
            rsp_v_d   = 1'b0;
            rsp_z_d   = 1'b0;
            rsp_n_d   = 1'b0;
            rsp_c_d   = 1'b0;
            rsp_err_d = 1'b1;
        end else if (rsp_valid && rsp_ready) begin
            rsp_f_d   = '0;
            rsp_v_d   = 1'b0;
            rsp_z_d   = 1'b0;
            rsp_n_d   = 1'b0;
            rsp_c_d   = 1'b0;
            rsp_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_q       <= CMD_ADD;
            a_hi_q     <= '0;
            b_hi_q     <= '0;
            a7_q       <= 1'b0;
            a0_q       <= 1'b0;
            res_q      <= '0;
            lo_c_q     <= 1'b0;
            hi_c_q     <= 1'b0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_cin_q  <= 1'b0;
            alu_op_q   <= '0;
            alu_mode_q <= 1'b0;
            rsp_f_q    <= '0;
            rsp_v_q    <= 1'b0;
            rsp_z_q    <= 1'b0;
            rsp_n_q    <= 1'b0;
            rsp_c_q    <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_hi_q     <= a_hi_d;
            b_hi_q     <= b_hi_d;
            a7_q       <= a7_d;
            a0_q       <= a0_d;
            res_q      <= res_d;
            lo_c_q     <= lo_c_d;
            hi_c_q     <= hi_c_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_cin_q  <= alu_cin_d;
            alu_op_q   <= alu_op_d;
            alu_mode_q <= alu_mode_d;
            rsp_f_q    <= rsp_f_d;
            rsp_v_q    <= rsp_v_d;
            rsp_z_q    <= rsp_z_d;
            rsp_n_q    <= rsp_n_d;
            rsp_c_q    <= rsp_c_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

`ifdef ALU16_SEQ_STICKY_V_EN
    logic sticky_v_q, sticky_v_d;

    // A set on the response handshake takes priority over a simultaneous clear.
    always_comb begin
        sticky_v_d = sticky_v_q;
        if (sticky_clr) begin
            sticky_v_d = 1'b0;
        end
        if (rsp_valid && rsp_ready && rsp_v_q) begin
            sticky_v_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_v_q <= 1'b0;
        end else begin
            sticky_v_q <= sticky_v_d;
        end
    end

    assign sticky_v = sticky_v_q;
`endif

endmodule

// File: tb/tb_alu16_seq.sv
// Directed + randomised bench for alu16_seq with a behavioural 8-bit ALU slice attached
// and a scoreboard of expected 16-bit responses.
module tb_alu16_seq;

    typedef struct packed {
        logic [15:0] f;
        logic        v;
        logic        z;
        logic        n;
        logic        c;
        logic        err;
        logic [3:0]  lat;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [15:0] cmd_a;
    logic [15:0] cmd_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_f;
    logic        rsp_v, rsp_z, rsp_n, rsp_c, rsp_err;
    logic [7:0]  alu_a, alu_b;
    logic        alu_cin;
    logic [3:0]  alu_op;
    logic        alu_mode;
    logic [7:0]  alu_f;
    logic        alu_v, alu_z, alu_n, alu_c;
    logic [8:0]  alu_t;
`ifdef ALU16_SEQ_STICKY_V_EN
    logic        sticky_v;
    logic        sticky_clr;
`endif

    exp_t        sbq[$];
    int          tests_run;
    int          tests_failed;

    alu16_seq dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_f     (rsp_f),
        .rsp_v     (rsp_v),
        .rsp_z     (rsp_z),
        .rsp_n     (rsp_n),
        .rsp_c     (rsp_c),
        .rsp_err   (rsp_err),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_cin   (alu_cin),
        .alu_op    (alu_op),
        .alu_mode  (alu_mode),
        .alu_f     (alu_f),
        .alu_v     (alu_v),
        .alu_z     (alu_z),
        .alu_n     (alu_n),
        .alu_c     (alu_c)
`ifdef ALU16_SEQ_STICKY_V_EN
        ,
        .sticky_v   (sticky_v),
        .sticky_clr (sticky_clr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural stand-in for the 8-bit ALU slice; C is a carry for adds and a borrow for subtracts.
    always_comb begin
        alu_t = '0;
        alu_f = alu_a;
        alu_c = 1'b0;
        case (alu_op)
            4'h0: begin alu_t = {1'b0, alu_a} + {1'b0, alu_b}; alu_f = alu_t[7:0]; alu_c = alu_t[8]; end
            4'h1: begin alu_f = alu_a - alu_b; alu_c = (alu_a < alu_b); end
            4'h2: begin alu_t = {1'b0, alu_a} + 9'd1; alu_f = alu_t[7:0]; alu_c = alu_t[8]; end
            4'h3: begin alu_f = alu_a - 8'd1; alu_c = (alu_a == 8'd0); end
            4'h4: begin alu_t = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin}; alu_f = alu_t[7:0]; alu_c = alu_t[8]; end
            4'h7: alu_f = alu_a | alu_b;
            4'h8: alu_f = alu_a & alu_b;
            4'h9: alu_f = ~alu_a;
            4'hA: alu_f = alu_a ^ alu_b;
            4'hB: begin alu_f = {alu_a[6:0], 1'b0}; alu_c = alu_a[7]; end
            4'hC: begin alu_f = {1'b0, alu_a[7:1]}; alu_c = alu_a[0]; end
            default: ;
        endcase
        alu_z = (alu_f == 8'd0);
        alu_n = alu_f[7];
        alu_v = 1'b0;
    end

    // Reference for a whole 16-bit command computed directly at 16 bits.
    function automatic exp_t refModel(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        exp_t        e;
        logic [16:0] s;
        logic [15:0] d;
        e = '0;
        e.lat = 4'd3;
        s = '0;
        d = '0;
        case (op)
            4'd0: begin s = {1'b0, a} + {1'b0, b}; e.f = s[15:0]; e.c = s[16];
                        e.v = (a[15] == b[15]) && (e.f[15] != a[15]); end
            4'd1: begin e.f = a - b; e.c = (a < b); e.v = (a[15] != b[15]) && (e.f[15] != a[15]);
                        if (a[7:0] < b[7:0]) e.lat = 4'd4; end
            4'd2: begin d = a - b; e.c = (a >= b); e.v = (a[15] != b[15]) && (d[15] != a[15]);
                        e.z = (d == 16'd0); e.n = d[15];
                        if (a[7:0] < b[7:0]) e.lat = 4'd4; end
            4'd3: begin s = {1'b0, a} + 17'd1; e.f = s[15:0]; e.c = s[16]; e.v = (a == 16'h7FFF); end
            4'd4: e.f = a & b;
            4'd5: e.f = a | b;
            4'd6: e.f = a ^ b;
            4'd7: e.f = ~a;
            4'd8: begin e.f = {a[14:0], 1'b0}; e.c = a[15]; end
            4'd9: begin e.f = {1'b0, a[15:1]}; e.c = a[0]; end
            default: begin e.err = 1'b1; e.lat = 4'd1; end
        endcase
        if (op != 4'd2 && op <= 4'd9) begin
            e.z = (e.f == 16'd0);
            e.n = e.f[15];
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string name, input int cycles, input int hold);
        exp_t e;
        e = sbq.pop_front();
        chk({name, " rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({name, " latency"}, 32'(cycles), 32'(e.lat));
        chk({name, " rsp_f"}, 32'(rsp_f), 32'(e.f));
        chk({name, " flags vznc_err"}, 32'({rsp_v, rsp_z, rsp_n, rsp_c, rsp_err}),
            32'({e.v, e.z, e.n, e.c, e.err}));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({name, " hold rsp"}, 32'({rsp_valid, rsp_f, rsp_v, rsp_z, rsp_n, rsp_c, rsp_err}),
                32'({1'b1, e.f, e.v, e.z, e.n, e.c, e.err}));
            chk({name, " hold cmd_ready"}, 32'(cmd_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk({name, " post rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({name, " post cmd_ready"}, 32'(cmd_ready), 32'd1);
    endtask

    task automatic applyStimulus(input string name, input logic [3:0] op, input logic [15:0] a,
                                 input logic [15:0] b, input int hold);
        int cycles;
        chk({name, " cmd_ready"}, 32'(cmd_ready), 32'd1);
        sbq.push_back(refModel(op, a, b));
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cycles    = 1;
        while (rsp_valid !== 1'b1 && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        checkOutput(name, cycles, hold);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        cmd_valid    = 1'b0;
        cmd_op       = 4'd0;
        cmd_a        = 16'd0;
        cmd_b        = 16'd0;
        rsp_ready    = 1'b0;
`ifdef ALU16_SEQ_STICKY_V_EN
        sticky_clr   = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("reset cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset rsp", 32'({rsp_valid, rsp_f, rsp_v, rsp_z, rsp_n, rsp_c, rsp_err}), 32'd0);
        chk("reset alu", 32'({alu_a, alu_b, alu_cin, alu_op, alu_mode}), 32'd0);

        applyStimulus("add_carry_byte", 4'd0, 16'h00FF, 16'h0001, 0);
        applyStimulus("sub_fix",        4'd1, 16'h1000, 16'h0001, 0);
        chk("sub_fix dec pass op", 32'(alu_op), 32'h3);
        chk("sub_fix dec pass a",  32'(alu_a),  32'h10);
        applyStimulus("sub_neg",        4'd1, 16'h0000, 16'h0001, 0);
        applyStimulus("add_ovf",        4'd0, 16'h7FFF, 16'h0001, 0);
        applyStimulus("cmp_equal",      4'd2, 16'h1234, 16'h1234, 0);
        applyStimulus("cmp_less",       4'd2, 16'h0001, 16'h0002, 0);
        applyStimulus("shl",            4'd8, 16'h8081, 16'h0000, 0);
        applyStimulus("shr",            4'd9, 16'h0101, 16'h0000, 0);
        applyStimulus("inc_wrap",       4'd3, 16'hFFFF, 16'h0000, 0);
        applyStimulus("inc_ovf",        4'd3, 16'h7FFF, 16'h0000, 0);
        applyStimulus("and",            4'd4, 16'hF0F0, 16'h3C3C, 0);
        applyStimulus("or",             4'd5, 16'h0F00, 16'h00F0, 0);
        applyStimulus("not",            4'd7, 16'h5A5A, 16'h0000, 0);
        applyStimulus("xor_zero_hold",  4'd6, 16'hFFFF, 16'hFFFF, 5);
        applyStimulus("illegal",        4'hC, 16'h1111, 16'h2222, 0);
        chk("illegal no pass op", 32'({alu_op, alu_mode}), 32'({4'hA, 1'b1}));
        chk("illegal no pass ab", 32'({alu_a, alu_b}), 32'hFFFF);

        for (int i = 0; i < 12; i++) begin
            applyStimulus("random", 4'($urandom_range(0, 9)), 16'($urandom), 16'($urandom), 0);
        end

        cmd_op    = 4'd0;
        cmd_a     = 16'h1234;
        cmd_b     = 16'h1111;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("abort hi pass op", 32'(alu_op), 32'h4);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort cmd_ready", 32'(cmd_ready), 32'd1);
        chk("abort alu_op", 32'(alu_op), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("abort no response", 32'(rsp_valid), 32'd0);

`ifdef ALU16_SEQ_STICKY_V_EN
        chk("sticky after reset", 32'(sticky_v), 32'd0);
        applyStimulus("sticky_add_ovf", 4'd0, 16'h7FFF, 16'h0001, 0);
        chk("sticky set", 32'(sticky_v), 32'd1);
        applyStimulus("sticky_add_plain", 4'd0, 16'h0001, 16'h0001, 0);
        chk("sticky held", 32'(sticky_v), 32'd1);
        sticky_clr = 1'b1;
        @(posedge clk);
        #1;
        sticky_clr = 1'b0;
        chk("sticky cleared", 32'(sticky_v), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alu16_seq.md
Name: alu16_seq

Overview:
- Initiator side of the 8-bit ALU interface: accepts 16-bit commands and drives the combinational 8-bit ALU slice over 2-3 passes (low byte, high byte, optional correction).
- Merges per-pass flags into 16-bit V/Z/N/C and returns the result on a valid/ready response port.
- Sits between the datapath control and the existing 8-bit ALU; the ALU is instantiated one level up.

Parameters:
- ALU_W, 8, ALU slice width; only 8 is supported.
- DATA_W, 16, command operand width; fixed at 2*ALU_W.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept
- cmd_op  in  4  0=ADD 1=SUB 2=CMP 3=INC 4=AND 5=OR 6=XOR 7=NOT 8=SHL 9=SHR; others illegal
- cmd_a, cmd_b  in  16  operands
- rsp_valid  out  1  result present
- rsp_ready  in  1  consumer accepts
- rsp_f  out  16  result
- rsp_v, rsp_z, rsp_n, rsp_c  out  1  16-bit flags
- rsp_err  out  1  illegal cmd_op
- alu_a, alu_b  out  8  ALU operands, registered
- alu_cin  out  1  ALU carry-in, registered
- alu_op  out  4  ALU opcode, registered
- alu_mode  out  1  0=arith, 1=logic, registered
- alu_f  in  8  ALU result
- alu_v, alu_z, alu_n, alu_c  in  1  ALU flags

Behaviour:
- Reset: state IDLE, cmd_ready=1, rsp_valid=0, and all rsp_*, alu_* outputs 0.
- Reset mid-operation aborts the command; nothing is returned.
- FSM states: IDLE, LO, HI, FIX, DONE.
- IDLE:
  - cmd_valid&cmd_ready latches the command and drives the low-byte ALU inputs, then goes to LO.
  - An illegal op goes straight to DONE with rsp_err=1, rsp_f=0 and all flags 0.
  - cmd_ready=1 only in IDLE.
- LO: capture alu_f into res[7:0] and save alu_c; drive the high-byte inputs; go to HI.
- HI: capture res[15:8]; go to FIX only for SUB/CMP when the low borrow=1, else go to DONE.
- FIX: drive DEC (0011) with a=res[15:8]; capture alu_f into res[15:8]; hi_borrow |= alu_c; go to DONE.
- DONE: rsp_valid=1, outputs held stable until rsp_ready; on handshake go to IDLE.
  - cmd_ready stays 0 in DONE, so there is no accept in the same cycle as the response.
- Pass mapping:
  - ADD: lo 0000; hi 0100 with cin=lo C.
  - SUB/CMP: lo 0001; hi 0001, then FIX if lo borrow. The ALU SUB-with-borrow opcode 0101 ignores cin and must not be used.
  - INC: lo 0010; hi 0100 with b=0, cin=lo C.
  - AND/OR/XOR/NOT: mode=1 with opcodes 1000/0111/1010/1001 on both bytes.
  - SHL: lo 1011; hi 1011; sequencer ORs a[7] into res[8].
  - SHR: lo 1100, hi 1100; sequencer ORs a[8] into res[7].
- Latency (accept edge to rsp_valid): 3 cycles normally, 4 cycles with FIX.
- Flags:
  - Z = (res==0).
  - N = res[15].
  - C (ADD/INC) = hi pass alu_c.
  - C (SUB) = borrow, i.e. 1 when a<b unsigned.
  - C (CMP) = ~borrow, i.e. a>=b unsigned.
  - V (ADD) = ~(a15^b15)&(a15^r15).
  - V (SUB/CMP) = (a15^b15)&(a15^r15).
  - V (INC) = ~a15&r15.
  - V = 0 for logic ops; C = 0 for logic ops except SHL, where C = a[15], and SHR, where C = a[0].
- CMP: rsp_f=0; Z/N/C/V computed from the internal difference.
- ALU flags alu_z/alu_n/alu_v are not used for 16-bit flags.

Optional Feature:
- Macro ALU16_SEQ_STICKY_V_EN.
- When defined: adds port sticky_v (out, 1) and sticky_clr (in, 1).
  - sticky_v sets on any response handshake with rsp_v=1 and clears on sticky_clr or rst.
  - If set and clear occur in the same cycle, set wins.
- When undefined: neither port exists and behaviour is otherwise identical.

Decomposition:
- Shared package alu_pkg holds:
  - 8-bit ALU opcode localparams (OP_ADD=0000 ... OP_ROR=1111) and MODE_ARITH/MODE_LOGIC.
  - The cmd_op enum.
  - The FSM state typedef.
- One natural sub-module: alu16_flag_merge, a combinational block computing V/Z/N/C from the command op, a15/b15/a0, res and the borrow/carry bits.

Test Plan:
- ADD 0x00FF+0x0001 -> rsp_f=0x0100, C=0, V=0, Z=0, N=0, 3-cycle latency.
- SUB 0x1000-0x0001 -> FIX pass taken, rsp_f=0x0FFF, C=0, 4-cycle latency; SUB 0x0000-0x0001 -> rsp_f=0xFFFF, C=1, N=1.
- ADD 0x7FFF+0x0001 -> rsp_f=0x8000, V=1, N=1; CMP 0x1234 vs 0x1234 -> rsp_f=0, Z=1, C=1.
- SHL 0x8081 -> rsp_f=0x0102, C=1; SHR 0x0101 -> rsp_f=0x0080, C=1; XOR 0xFFFF^0xFFFF -> Z=1.
- Hold rsp_ready=0 for 5 cycles -> rsp_* stable and cmd_ready=0 throughout; cmd_op=0xC -> rsp_err=1, no ALU pass issued.
- Assert rst in HI state -> next cycle IDLE, rsp_valid=0, cmd_ready=1; with ALU16_SEQ_STICKY_V_EN, an overflowing ADD sets sticky_v and it stays set until sticky_clr.
